// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding,
// default sizing constants and a small index-width helper.
package mult_arbiter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Start/done handshake between the arbiter (master) and the shared
// sequential multiplier core (slave).
interface mult_arbiter_if import mult_arbiter_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);

    logic                   mult_start;
    logic [WIDTH-1:0]       mult_a;
    logic [WIDTH-1:0]       mult_b;
    logic                   mult_done;
    logic [2*WIDTH-1:0]     mult_res;

    modport master (
        output mult_start, mult_a, mult_b,
        input  mult_done, mult_res
    );

    modport slave (
        input  mult_start, mult_a, mult_b,
        output mult_done, mult_res
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req starting one past the
// last served index and wraps around, reporting the first hit.
module rr_pick import mult_arbiter_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    // One extra bit so last + offset cannot overflow before the wrap.
    localparam int SW = IDW + 1;

    logic [IDW-1:0]  cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;

    // Candidate gi is the requester gi+1 places after last, wrapped with a
    // single conditional subtract instead of a general modulo.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [SW-1:0] raw;
            assign raw          = {1'b0, last} + SW'(gi + 1);
            assign cand_idx[gi] = IDW'((raw >= SW'(NREQ)) ? raw - SW'(NREQ) : raw);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest candidate offset with an active request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found  = 1'b1;
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between NREQ requesters. A round-robin
// winner's operands are latched, the core is started, and its product (or
// a watchdog abort) is returned to the winner with a one-cycle ack.
module mult_arbiter import mult_arbiter_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       a_in,
    input  logic [NREQ*WIDTH-1:0]       b_in,
    output logic [NREQ-1:0]             ack,
    output logic [2*WIDTH-1:0]          res_out,
    output logic                        err,
    output logic                        busy,
    output logic [idx_width(NREQ)-1:0]  grant_id,
    mult_arbiter_if.master              mif
);

    localparam int IDW = idx_width(NREQ);
    localparam int WDW = idx_width(TIMEOUT);

    state_t             state_reg;
    logic [IDW-1:0]     last_reg;
    logic [IDW-1:0]     grant_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               start_reg;
    logic [NREQ-1:0]    ack_reg;
    logic [2*WIDTH-1:0] res_reg;
    logic               err_reg;
    logic [WDW-1:0]     wdog_reg;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];
    logic               pick_found;
    logic [IDW-1:0]     pick_winner;

    // Split the flat operand buses into per-requester slices.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .last   (last_reg),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Arbitration FSM; start and ack are single-cycle strobes that fall
    // back to zero unless the current transition raises them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= IDW'(NREQ - 1);
            grant_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            start_reg <= 1'b0;
            ack_reg   <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            wdog_reg  <= '0;
        end else begin
            start_reg <= 1'b0;
            ack_reg   <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        a_reg     <= a_arr[pick_winner];
                        b_reg     <= b_arr[pick_winner];
                        grant_reg <= pick_winner;
                        start_reg <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A done seen while start is still high is ignored.
                    wdog_reg  <= '0;
                    state_reg <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Done has priority over a timeout in the same cycle.
                    if (mif.mult_done) begin
                        res_reg   <= mif.mult_res;
                        err_reg   <= 1'b0;
                        ack_reg   <= NREQ'(1) << grant_reg;
                        state_reg <= ST_DELIVER;
                    end else if (wdog_reg == WDW'(TIMEOUT - 1)) begin
                        res_reg   <= '0;
                        err_reg   <= 1'b1;
                        ack_reg   <= NREQ'(1) << grant_reg;
                        state_reg <= ST_DELIVER;
                    end else begin
                        wdog_reg  <= wdog_reg + WDW'(1);
                    end
                end
                ST_DELIVER: begin
                    last_reg  <= grant_reg;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ack            = ack_reg;
    assign res_out        = res_reg;
    assign err            = err_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign grant_id       = grant_reg;
    assign mif.mult_start = start_reg;
    assign mif.mult_a     = a_reg;
    assign mif.mult_b     = b_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios followed by randomized
// requester/multiplier traffic, all checked against a transaction-level model.
module tb_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int PW      = 2 * WIDTH;
    localparam int NEVER   = 1000;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NREQ-1:0]           req;
    logic [NREQ*WIDTH-1:0]     a_in;
    logic [NREQ*WIDTH-1:0]     b_in;
    logic [NREQ-1:0]           ack;
    logic [PW-1:0]             res_out;
    logic                      err;
    logic                      busy;
    logic [$clog2(NREQ)-1:0]   grant_id;

    mult_arbiter_if #(.WIDTH(WIDTH)) mif ();

    mult_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .ack      (ack),
        .res_out  (res_out),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .mif      (mif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Requester state
    bit               pend [NREQ];
    logic [WIDTH-1:0] opa  [NREQ];
    logic [WIDTH-1:0] opb  [NREQ];

    // Transaction-level model of the arbiter
    bit            m_idle;
    int            m_last, m_win, m_start_cyc, m_ack_cyc;
    logic [PW-1:0] m_res;
    bit            m_err;
    int            dn_lo, dn_hi;
    logic [PW-1:0] dn_prod;
    bit            stray_next;

    bit auto_req, spur_en, force_spur;
    int delay_q [$];

    // Observations for directed checks
    int            obs_ack_cnt = 0, obs_ack_id = -1, obs_ack_cyc = 0;
    int            obs_start_cnt = 0, obs_start_cyc = 0;
    logic [PW-1:0] obs_res;
    logic          obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_idle      = 1'b1;
        m_last      = NREQ - 1;
        m_win       = 0;
        m_start_cyc = -1;
        m_ack_cyc   = -1;
        dn_lo       = -1;
        dn_hi       = -2;
    endfunction

    function automatic void raise(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        int r = $urandom % 8;
        if (r == 0) return '0;
        if (r == 1) return '1;
        return WIDTH'($urandom);
    endfunction

    function automatic int rand_delay();
        int r = $urandom % 10;
        if (r == 0) return NEVER;
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return TIMEOUT;
        return $urandom % 10;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            req[i]                  = pend[i];
            a_in[i*WIDTH +: WIDTH]  = opa[i];
            b_in[i*WIDTH +: WIDTH]  = opb[i];
        end
    endtask

    // One clock cycle: check this cycle's outputs, then set this cycle's inputs.
    task automatic step(input bit do_rst);
        bit              idle_now, in_win, spur_ok, directed;
        int              c, w, k, len;
        logic [NREQ-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        c = cyc;

        exp_ack = '0;
        if (c == m_ack_cyc) exp_ack[m_win] = 1'b1;
        check("busy", busy, !m_idle);
        check("mult_start", mif.mult_start, c == m_start_cyc);
        check("ack", ack, exp_ack);
        if (!m_idle) check("grant_id", grant_id, m_win);
        if (c == m_start_cyc) begin
            check("mult_a", mif.mult_a, opa[m_win]);
            check("mult_b", mif.mult_b, opb[m_win]);
        end
        if (c == m_ack_cyc) begin
            check("res_out", res_out, m_res);
            check("err", err, m_err);
        end

        if (mif.mult_start === 1'b1) begin
            obs_start_cnt++;
            obs_start_cyc = c;
        end
        if (ack !== '0) begin
            obs_ack_cnt++;
            obs_ack_cyc = c;
            obs_res     = res_out;
            obs_err     = err;
            for (int i = 0; i < NREQ; i++) if (ack[i]) obs_ack_id = i;
        end

        idle_now = m_idle;
        if (do_rst) begin
            reset = 1'b1;
            model_reset();
            mif.mult_done = 1'b1;
            mif.mult_res  = PW'($urandom);
            stray_next    = 1'b1;
            drive_req();
            return;
        end
        reset = 1'b0;

        if (c == m_ack_cyc) begin
            pend[m_win] = 1'b0;
            m_last      = m_win;
            m_idle      = 1'b1;
        end

        if (auto_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    if (!(!idle_now && i == m_win) && ($urandom % 40 == 0)) pend[i] = 1'b0;
                end else if (!(c == m_ack_cyc && i == m_win) && ($urandom % 4 == 0)) begin
                    raise(i, rand_op(), rand_op());
                end
            end
        end

        in_win  = (c >= dn_lo) && (c <= dn_hi);
        spur_ok = idle_now || (c == m_start_cyc) || (c == m_ack_cyc);
        mif.mult_done = in_win || stray_next ||
                        (spur_ok && (force_spur || (spur_en && ($urandom % 6 == 0))));
        mif.mult_res  = in_win ? dn_prod : PW'($urandom);
        stray_next    = 1'b0;

        if (idle_now) begin
            w = -1;
            for (int j = 1; j <= NREQ; j++) begin
                if (w < 0 && pend[(m_last + j) % NREQ]) w = (m_last + j) % NREQ;
            end
            if (w >= 0) begin
                directed = (delay_q.size() != 0);
                k        = directed ? delay_q.pop_front() : rand_delay();
                len      = directed ? 1 : 1 + ($urandom % 3);
                m_win       = w;
                m_idle      = 1'b0;
                m_start_cyc = c + 1;
                dn_prod     = PW'(opa[w]) * PW'(opb[w]);
                if (k <= TIMEOUT - 1) begin
                    m_ack_cyc = c + 3 + k;
                    m_res     = dn_prod;
                    m_err     = 1'b0;
                end else begin
                    m_ack_cyc = c + 2 + TIMEOUT;
                    m_res     = '0;
                    m_err     = 1'b1;
                end
                if (k == NEVER) begin
                    dn_lo = -1;
                    dn_hi = -2;
                end else begin
                    dn_lo = c + 2 + k;
                    dn_hi = dn_lo + len - 1;
                end
            end
        end
        drive_req();
    endtask

    task automatic wait_ack(input string tag, input int maxc);
        int n0 = obs_ack_cnt;
        int t  = 0;
        while (obs_ack_cnt == n0 && t < maxc) begin
            step(1'b0);
            t++;
        end
        check({tag, "_acks"}, obs_ack_cnt - n0, 1);
    endtask

    initial begin
        int s0, t;
        reset = 1'b1;
        req = '0; a_in = '0; b_in = '0;
        mif.mult_done = 1'b0;
        mif.mult_res  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; opa[i] = '0; opb[i] = '0;
        end
        model_reset();
        auto_req = 0; spur_en = 0; force_spur = 0; stray_next = 0;

        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_res", res_out, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_start", mif.mult_start, 0);
        check("rst_mult_a", mif.mult_a, 0);
        check("rst_mult_b", mif.mult_b, 0);

        // Single request, done 8 cycles after start
        raise(0, 12, 13);
        delay_q.push_back(7);
        s0 = obs_start_cnt;
        wait_ack("single", 40);
        check("single_id", obs_ack_id, 0);
        check("single_res", obs_res, 156);
        check("single_err", obs_err, 0);
        check("single_lat", obs_ack_cyc - obs_start_cyc, 9);
        check("single_starts", obs_start_cnt - s0, 1);

        // Contention right after reset: 0,1,0,1
        step(1'b1);
        delay_q = {3, 5, 0, 2};
        for (int r = 0; r < 4; r++) begin
            if (!pend[0]) raise(0, WIDTH'(r * 37 + 5), 200);
            if (!pend[1]) raise(1, 255, 255);
            wait_ack("cont", 40);
            check("cont_id", obs_ack_id, r % 2);
            if (r % 2 == 1) check("cont_res1", obs_res, 65025);
        end
        pend[0] = 1'b0;

        // Timeout, then a normal service
        raise(0, 9, 9);
        delay_q.push_back(NEVER);
        wait_ack("timeout", 60);
        check("to_err", obs_err, 1);
        check("to_res", obs_res, 0);
        check("to_lat", obs_ack_cyc - obs_start_cyc, TIMEOUT + 1);
        raise(1, 3, 5);
        delay_q.push_back(2);
        wait_ack("after_to", 40);
        check("after_to_id", obs_ack_id, 1);
        check("after_to_res", obs_res, 15);
        check("after_to_err", obs_err, 0);

        // Done coincides with the final watchdog cycle
        raise(0, 6, 7);
        delay_q.push_back(TIMEOUT - 1);
        wait_ack("coincide", 60);
        check("coin_err", obs_err, 0);
        check("coin_res", obs_res, 42);
        check("coin_lat", obs_ack_cyc - obs_start_cyc, TIMEOUT + 1);

        // Reset while requester 1 is in BUSY, with a stray done afterwards
        raise(0, 4, 4);
        raise(1, 10, 10);
        delay_q = {NEVER, 3, 4};
        s0 = obs_ack_cnt;
        repeat (6) step(1'b0);
        step(1'b1);
        step(1'b0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", ack, 0);
        wait_ack("rst_next", 40);
        check("rst_next_id", obs_ack_id, 0);
        check("rst_next_res", obs_res, 16);
        wait_ack("rst_next2", 40);
        check("rst_next2_id", obs_ack_id, 1);
        check("rst_next2_res", obs_res, 100);
        check("rst_ack_total", obs_ack_cnt - s0, 2);

        // Spurious done in IDLE, ISSUE and DELIVER
        force_spur = 1;
        s0 = obs_ack_cnt;
        repeat (3) step(1'b0);
        check("spur_idle_acks", obs_ack_cnt - s0, 0);
        raise(0, 11, 11);
        delay_q.push_back(5);
        wait_ack("spur", 40);
        check("spur_res", obs_res, 121);
        check("spur_err", obs_err, 0);
        force_spur = 0;

        // Randomized traffic
        auto_req = 1;
        spur_en  = 1;
        repeat (3000) step(1'b0);
        auto_req = 0;
        spur_en  = 0;
        t = 0;
        while ((!m_idle || pend[0] || pend[1]) && t < 200) begin
            step(1'b0);
            t++;
        end
        step(1'b0);
        check("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
